// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment value display: FSM encodings,
// digit code layout and active-low segment patterns {DP,g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 5;

  // Digit code is {blank, nibble}; a set blank flag turns every segment off.
  typedef logic [DIGIT_W-1:0] digit_code_t;
  localparam digit_code_t DIGIT_BLANK = 5'b1_0000;

  localparam logic [7:0] BLANK_SEG = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic digit_code_t show(input logic [3:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to active-low segment pattern decoder.
module seg7_decoder
  import seven_seg_pkg::*;
(
  input  digit_code_t digit_code,
  output logic [7:0]  seg
);

  always_comb begin
    seg = BLANK_SEG;
    if (!digit_code[DIGIT_W-1]) begin
      case (digit_code[3:0])
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_value_display.sv
// 8-bit value to 4-digit multiplexed seven-segment display: sequential
// double-dabble converter feeding a digit register scanned at REFRESH_DIV.
module seven_seg_value_display
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] VALUE_IN,
  input  logic       HEX_MODE,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT,
  output logic       CONV_BUSY
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [1:0]  state;
  logic [7:0]  bin;
  logic [7:0]  cap_value;
  logic        mode;
  logic [11:0] bcd;
  logic [2:0]  shift_cnt;
  logic [7:0]  last_value;
  logic        last_mode;
  logic        first;

  digit_code_t [NUM_DIGITS-1:0] digits;
  digit_code_t [NUM_DIGITS-1:0] load_digits;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       index;
  logic [7:0]       seg_next;

  logic [11:0] bcd_adj;
  logic [19:0] dabble;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  assign dabble = {bcd_adj, bin} << 1;

  // Decimal blanks leading zeros, but a zero tens digit under a nonzero hundreds stays lit.
  always_comb begin
    load_digits = {NUM_DIGITS{DIGIT_BLANK}};
    if (mode) begin
      load_digits[0] = show(cap_value[3:0]);
      load_digits[1] = show(cap_value[7:4]);
    end else begin
      load_digits[0] = show(bcd[3:0]);
      if (bcd[11:4] != 8'd0) load_digits[1] = show(bcd[7:4]);
      if (bcd[11:8] != 4'd0) load_digits[2] = show(bcd[11:8]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      bin        <= '0;
      cap_value  <= '0;
      mode       <= 1'b0;
      bcd        <= '0;
      shift_cnt  <= '0;
      last_value <= '0;
      last_mode  <= 1'b0;
      first      <= 1'b1;
      digits     <= {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, show(4'd0)};
    end else begin
      case (state)
        ST_IDLE: begin
          if (first || ({VALUE_IN, HEX_MODE} != {last_value, last_mode})) begin
            bin       <= VALUE_IN;
            cap_value <= VALUE_IN;
            mode      <= HEX_MODE;
            bcd       <= '0;
            shift_cnt <= '0;
            state     <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {bcd, bin} <= dabble;
          shift_cnt  <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) state <= ST_LOAD;
        end
        ST_LOAD: begin
          digits     <= load_digits;
          last_value <= cap_value;
          last_mode  <= mode;
          first      <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign CONV_BUSY = (state != ST_IDLE);

  seg7_decoder u_dec (
    .digit_code (digits[index]),
    .seg        (seg_next)
  );

  // Select and segments come from the same index, so they always switch together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt    <= '0;
      index          <= '0;
      SEG_SELECT_OUT <= 4'b1110;
      HEX_OUT        <= SEG_0;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        index       <= index + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      SEG_SELECT_OUT <= ~(4'b0001 << index);
      HEX_OUT        <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_value_display.sv
// Self-checking bench: directed table, multi-cycle corner sequences and
// randomized values checked against an arithmetic display model.
module tb_seven_seg_value_display;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] VALUE_IN;
  logic       HEX_MODE;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;
  logic       CONV_BUSY;

  int passed = 0;
  int total  = 0;

  logic [7:0] lv;
  logic       lm;

  localparam logic [7:0] SEGTAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seven_seg_value_display #(.REFRESH_DIV(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .VALUE_IN       (VALUE_IN),
    .HEX_MODE       (HEX_MODE),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT),
    .CONV_BUSY      (CONV_BUSY)
  );

  always #5 CLK = ~CLK;

  // Expected patterns packed {digit3, digit2, digit1, digit0}.
  typedef struct {
    logic [7:0]  value;
    logic        mode;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [7:0] v, input logic m);
    logic [31:0] r;
    int u, t, h;
    r = 32'hFFFF_FFFF;
    if (m) begin
      r[7:0]  = SEGTAB[v[3:0]];
      r[15:8] = SEGTAB[v[7:4]];
    end else begin
      u = int'(v) % 10;
      t = (int'(v) / 10) % 10;
      h = int'(v) / 100;
      r[7:0] = SEGTAB[u];
      if (v >= 8'd10) r[15:8]  = SEGTAB[t];
      if (h != 0)     r[23:16] = SEGTAB[h];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_sample(input logic [31:0] exp, input string nm, output int idx);
    case (SEG_SELECT_OUT)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    if (idx < 0) chk({nm, "_select_onehot"}, {28'd0, SEG_SELECT_OUT}, 32'he);
    else chk({nm, "_seg"}, {24'd0, HEX_OUT}, {24'd0, exp[idx*8 +: 8]});
  endtask

  task automatic check_display(input logic [31:0] exp, input string nm);
    logic [3:0] seen, prev;
    int idx, busy_cnt;
    seen = '0; busy_cnt = 0; prev = SEG_SELECT_OUT;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_sample(exp, nm, idx);
      if (idx >= 0) seen[idx] = 1'b1;
      if (SEG_SELECT_OUT != prev)
        chk({nm, "_scan_order"}, {28'd0, SEG_SELECT_OUT}, {28'd0, prev[2:0], prev[3]});
      prev = SEG_SELECT_OUT;
      if (CONV_BUSY) busy_cnt++;
    end
    chk({nm, "_all_digits"}, {28'd0, seen}, 32'hF);
    chk({nm, "_no_extra_conv"}, busy_cnt, 0);
  endtask

  // Waits up to a bound for busy to rise; leaves us at the first busy sample.
  task automatic wait_busy(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (CONV_BUSY) ok = 1'b1;
    end
    if (!ok) chk({nm, "_busy_rise"}, 0, 1);
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (CONV_BUSY && n < 40) begin
      n++;
      @(negedge CLK);
    end
    chk({nm, "_busy_len"}, n, 9);
  endtask

  task automatic apply(input logic [7:0] v, input logic m, input logic [31:0] exp, input string nm);
    bit ok, conv;
    conv = ({v, m} != {lv, lm});
    VALUE_IN = v; HEX_MODE = m;
    lv = v; lm = m;
    if (conv) begin
      wait_busy(nm, ok);
      if (ok) count_busy(nm);
    end
    check_display(exp, nm);
  endtask

  vec_t vecs [6];

  initial begin
    bit ok;
    int n, idx;
    logic [7:0] rv;
    logic       rm;

    vecs[0] = '{8'd255, 1'b0, 32'hFFA49292};
    vecs[1] = '{8'd0,   1'b0, 32'hFFFFFFC0};  // counter wrap 255 -> 0
    vecs[2] = '{8'd7,   1'b0, 32'hFFFFFFF8};
    vecs[3] = '{8'd100, 1'b0, 32'hFFF9C0C0};
    vecs[4] = '{8'hA5,  1'b1, 32'hFFFF8892};
    vecs[5] = '{8'hA5,  1'b0, 32'hFFF98292};  // HEX_MODE toggle alone

    RESET = 1'b1; VALUE_IN = 8'd0; HEX_MODE = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_sel",  {28'd0, SEG_SELECT_OUT}, 32'hE);
    chk("reset_hex",  {24'd0, HEX_OUT}, 32'hC0);
    chk("reset_busy", {31'd0, CONV_BUSY}, 0);

    RESET = 1'b0;
    lv = 8'd0; lm = 1'b0;
    wait_busy("post_reset", ok);
    if (ok) count_busy("post_reset");
    check_display(32'hFFFFFFC0, "post_reset");

    for (int i = 0; i < 6; i++)
      apply(vecs[i].value, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));

    // A change during CONVERT is picked up right after LOAD.
    VALUE_IN = 8'd12; HEX_MODE = 1'b0;
    wait_busy("v12", ok);
    if (ok) begin
      n = 0;
      while (CONV_BUSY && n < 40) begin
        n++;
        if (n == 4) VALUE_IN = 8'd34;
        @(negedge CLK);
      end
      chk("v12_busy_len", n, 9);
      chk("v12_gap", {31'd0, CONV_BUSY}, 0);
      @(negedge CLK);
      chk("v34_busy_restart", {31'd0, CONV_BUSY}, 1);
      n = 0;
      while (CONV_BUSY && n < 40) begin
        n++;
        check_sample(32'hFFFFF9A4, "v12_shown", idx);
        @(negedge CLK);
      end
      chk("v34_busy_len", n, 9);
    end
    lv = 8'd34; lm = 1'b0;
    check_display(32'hFFFFB099, "v34");

    // Reset during the 4th shift discards the partial conversion.
    VALUE_IN = 8'd200;
    wait_busy("v200", ok);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset_sel",  {28'd0, SEG_SELECT_OUT}, 32'hE);
    chk("midreset_hex",  {24'd0, HEX_OUT}, 32'hC0);
    chk("midreset_busy", {31'd0, CONV_BUSY}, 0);
    RESET = 1'b0;
    wait_busy("v200_redo", ok);
    if (ok) count_busy("v200_redo");
    lv = 8'd200; lm = 1'b0;
    check_display(32'hFFA4C0C0, "v200");

    for (int i = 0; i < 24; i++) begin
      rv = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      apply(rv, rm, model(rv, rm), $sformatf("rand%0d_%0d_%0d", i, rv, rm));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
